// File: rtl/hazard_bubble_unit_pkg.sv
// Shared definitions for the ID-stage hazard unit: control bundle layout and FSM encodings.
package hazard_bubble_unit_pkg;

  typedef struct packed {
    logic       reg_dest;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [2:0] mem;
    logic [1:0] wb;
  } ctrl_t;

  localparam int CTRL_W = $bits(ctrl_t);

  localparam logic [1:0] HZ_RUN   = 2'd0;
  localparam logic [1:0] HZ_STALL = 2'd1;
  localparam logic [1:0] HZ_FLUSH = 2'd2;

endpackage

// File: rtl/hazard_bubble_unit_if.sv
// ID/EX-side signal bundle between the decode stage and the hazard unit.
interface hazard_bubble_unit_if
  import hazard_bubble_unit_pkg::*;
#(
  parameter int CTRL_W_P = CTRL_W,
  parameter int REG_AW   = 5,
  parameter int CNT_W    = 16
);
  logic              idValid;
  logic [REG_AW-1:0] idRs;
  logic [REG_AW-1:0] idRt;
  logic              idUsesRt;
  logic [CTRL_W_P-1:0] idCtrl;
  logic              exMemRead;
  logic [REG_AW-1:0] exRt;
  logic              branchTaken;
  logic              pcWrite;
  logic              ifIdWrite;
  logic              ifIdFlush;
  logic [CTRL_W_P-1:0] exCtrl;
  logic              exBubble;
  logic [1:0]        hzdState;
  logic [CNT_W-1:0]  stallCount;

  modport master (
    output idValid, idRs, idRt, idUsesRt, idCtrl, exMemRead, exRt, branchTaken,
    input  pcWrite, ifIdWrite, ifIdFlush, exCtrl, exBubble, hzdState, stallCount
  );

  modport slave (
    input  idValid, idRs, idRt, idUsesRt, idCtrl, exMemRead, exRt, branchTaken,
    output pcWrite, ifIdWrite, ifIdFlush, exCtrl, exBubble, hzdState, stallCount
  );
endinterface

// File: rtl/hazard_bubble_unit_hazard_detect.sv
// Combinational load-use compare; r0 is never a real dependency.
module hazard_detect #(
  parameter int REG_AW = 5
) (
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rt,
  output logic              hz
);
  assign hz = id_valid & ex_mem_read & (ex_rt != '0) &
              ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)));
endmodule

// File: rtl/hazard_bubble_unit.sv
// Load-use stall / branch flush sequencer that owns the ID/EX control register and bubble injection.
module hazard_bubble_unit
  import hazard_bubble_unit_pkg::*;
#(
  parameter int CTRL_W_P  = CTRL_W,
  parameter int REG_AW    = 5,
  parameter int LOAD_LAT  = 1,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  hazard_bubble_unit_if.slave  bus
);

  logic [1:0]          state, state_nxt;
  logic [1:0]          cnt, cnt_nxt;
  logic [CTRL_W_P-1:0] ex_ctrl;
  logic                ex_bubble;
  logic [CNT_W-1:0]    stall_count;
  logic                hz;
  logic                pc_write, if_id_write, if_id_flush, bubble, count_bubble;

  hazard_detect #(.REG_AW(REG_AW)) u_detect (
    .id_valid    (bus.idValid),
    .id_rs       (bus.idRs),
    .id_rt       (bus.idRt),
    .id_uses_rt  (bus.idUsesRt),
    .ex_mem_read (bus.exMemRead),
    .ex_rt       (bus.exRt),
    .hz          (hz)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    state_nxt    = state;
    cnt_nxt      = cnt;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    bubble       = 1'b1;
    count_bubble = 1'b0;
    if (bus.branchTaken) begin
      if_id_flush = 1'b1;
      if (state == HZ_FLUSH) begin
        cnt_nxt      = 2'(FLUSH_CYC - 1);
        count_bubble = 1'b1;
      end else if (FLUSH_CYC > 1) begin
        state_nxt = HZ_FLUSH;
        cnt_nxt   = 2'(FLUSH_CYC - 1);
      end else begin
        state_nxt = HZ_RUN;
      end
    end else begin
      case (state)
        HZ_STALL: begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          count_bubble = 1'b1;
          cnt_nxt      = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = HZ_RUN;
        end
        HZ_FLUSH: begin
          if_id_flush  = 1'b1;
          count_bubble = 1'b1;
          cnt_nxt      = cnt - 2'd1;
          if (cnt == 2'd1) state_nxt = HZ_RUN;
        end
        default: begin
          if (hz) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            count_bubble = 1'b1;
            if (LOAD_LAT > 1) begin
              state_nxt = HZ_STALL;
              cnt_nxt   = 2'(LOAD_LAT - 1);
            end
          end else begin
            bubble = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    if (!reset) begin
      state       <= HZ_RUN;
      cnt         <= 2'd0;
      ex_ctrl     <= '0;
      ex_bubble   <= 1'b1;
      stall_count <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      ex_ctrl   <= bubble ? '0 : bus.idCtrl;
      ex_bubble <= bubble;
      if (count_bubble && (stall_count != '1)) stall_count <= stall_count + CNT_W'(1);
    end
  end

  // Enables are forced safe while reset is held, independent of the FSM.
  assign bus.pcWrite    = reset & pc_write;
  assign bus.ifIdWrite  = reset & if_id_write;
  assign bus.ifIdFlush  = ~reset | if_id_flush;
  assign bus.exCtrl     = ex_ctrl;
  assign bus.exBubble   = ex_bubble;
  assign bus.hzdState   = state;
  assign bus.stallCount = stall_count;

endmodule
